// File: rtl/mem_ctrl_if.sv
// Cache-arbiter-side bus of the main-memory responder: icache/dcache requests and the shared fill return.
interface mem_ctrl_if #(
    parameter int ADDRESS_WIDTH    = 32,
    parameter int CACHE_LINE_WIDTH = 128
);
    logic                        i_req_in;
    logic [ADDRESS_WIDTH-1:0]    i_addr_in;
    logic                        i_grant_out;
    logic                        i_fill_out;
    logic                        d_req_in;
    logic                        d_write_in;
    logic [ADDRESS_WIDTH-1:0]    d_addr_in;
    logic [CACHE_LINE_WIDTH-1:0] d_data_in;
    logic                        d_grant_out;
    logic                        d_fill_out;
    logic [CACHE_LINE_WIDTH-1:0] fill_data_out;
    logic [ADDRESS_WIDTH-1:0]    fill_addr_out;
    logic                        fill_write_out;

    modport slave (
        input  i_req_in, i_addr_in, d_req_in, d_write_in, d_addr_in, d_data_in,
        output i_grant_out, i_fill_out, d_grant_out, d_fill_out,
               fill_data_out, fill_addr_out, fill_write_out
    );

    modport master (
        output i_req_in, i_addr_in, d_req_in, d_write_in, d_addr_in, d_data_in,
        input  i_grant_out, i_fill_out, d_grant_out, d_fill_out,
               fill_data_out, fill_addr_out, fill_write_out
    );
endinterface

// File: rtl/mem_ctrl.sv
// Main-memory responder: arbitrates icache/dcache line requests, fixed-latency access, one-cycle fill.
// Define MEM_CTRL_RR_ARB_EN for round-robin arbitration instead of fixed dcache-over-icache priority.
module mem_ctrl #(
    parameter int ADDRESS_WIDTH    = 32,
    parameter int CACHE_LINE_WIDTH = 128,
    parameter int MEM_LINES        = 4096,
    parameter int MEM_LATENCY      = 5
) (
    input  logic       clk,
    input  logic       reset,
    mem_ctrl_if.slave  bus
);
    localparam int OFF  = $clog2(CACHE_LINE_WIDTH / 8);
    localparam int IDXW = $clog2(MEM_LINES);
    localparam int CNTW = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                      state_q, state_d;
    logic [CNTW-1:0]             cnt_q, cnt_d;
    logic                        port_q, port_d;   // 1 = dcache
    logic                        wr_q, wr_d;
    logic [ADDRESS_WIDTH-1:0]    addr_q, addr_d;
    logic [CACHE_LINE_WIDTH-1:0] data_q, data_d;
    logic [CACHE_LINE_WIDTH-1:0] rd_q;
    logic                        rd_en, mem_we;
    logic                        win_d;
    logic [IDXW-1:0]             idx;

    logic [CACHE_LINE_WIDTH-1:0] mem_q [MEM_LINES];

    assign idx = addr_q[OFF +: IDXW];

`ifdef MEM_CTRL_RR_ARB_EN
    logic last_q;   // last winner, 1 = dcache
    assign win_d = bus.d_req_in & (~bus.i_req_in | ~last_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                               last_q <= 1'b0;
        else if (state_q == IDLE && state_d == BUSY) last_q <= win_d;
    end
`else
    assign win_d = bus.d_req_in;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            port_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            port_q  <= port_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rd_en   = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_req_in || bus.d_req_in) begin
                    port_d  = win_d;
                    wr_d    = win_d & bus.d_write_in;
                    addr_d  = win_d ? bus.d_addr_in : bus.i_addr_in;
                    data_d  = bus.d_data_in;
                    cnt_d   = CNTW'(MEM_LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    // Array read lands in rd_q exactly as RESP begins.
                    rd_en   = ~wr_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            RESP: begin
                mem_we  = wr_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Backing array has no reset; a write only commits at the edge that ends RESP.
    always_ff @(posedge clk) begin
        if (rd_en)  rd_q       <= mem_q[idx];
        if (mem_we) mem_q[idx] <= data_q;
    end

    logic resp, busy_or_resp;
    assign resp         = (state_q == RESP);
    assign busy_or_resp = (state_q != IDLE);

    assign bus.i_grant_out    = busy_or_resp & ~port_q;
    assign bus.d_grant_out    = busy_or_resp &  port_q;
    assign bus.i_fill_out     = resp & ~port_q;
    assign bus.d_fill_out     = resp &  port_q;
    assign bus.fill_write_out = resp & wr_q;
    assign bus.fill_addr_out  = resp ? {addr_q[ADDRESS_WIDTH-1:OFF], {OFF{1'b0}}} : '0;
    assign bus.fill_data_out  = resp ? (wr_q ? data_q : rd_q) : '0;
endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized self-checking bench for mem_ctrl against a line-array/arbitration reference model.
module tb_mem_ctrl;
    localparam int AW  = 32;
    localparam int LW  = 128;
    localparam int ML  = 4096;
    localparam int LAT = 5;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [LW-1:0] mem_m [int];
    bit            last_m = 1'b0;   // last winner, 1 = dcache

    mem_ctrl_if #(.ADDRESS_WIDTH(AW), .CACHE_LINE_WIDTH(LW)) bus ();
    mem_ctrl #(.ADDRESS_WIDTH(AW), .CACHE_LINE_WIDTH(LW), .MEM_LINES(ML), .MEM_LATENCY(LAT))
        dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [AW-1:0] a);
        return int'((a / 32'(LW / 8)) % 32'(ML));
    endfunction

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a - (a % 32'(LW / 8));
    endfunction

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_ig"}, bus.i_grant_out, 0);
        chk({tag, "_dg"}, bus.d_grant_out, 0);
        chk({tag, "_fill"}, {bus.i_fill_out, bus.d_fill_out, bus.fill_write_out}, 0);
        chk({tag, "_fd"}, bus.fill_data_out, 0);
        chk({tag, "_fa"}, bus.fill_addr_out, 0);
    endtask

    // Single transaction on one port; checks grant window, latency and fill contents.
    task automatic xact(input bit port, input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] data);
        int n = 0;
        bit got = 0;
        logic [LW-1:0] exp_d;
        exp_d = wr ? data : (mem_m.exists(idx_of(addr)) ? mem_m[idx_of(addr)] : 'x);
        @(negedge clk);
        if (port) begin
            bus.d_req_in = 1; bus.d_write_in = wr; bus.d_addr_in = addr; bus.d_data_in = data;
        end else begin
            bus.i_req_in = 1; bus.i_addr_in = addr;
        end
        while (!got && n < 40) begin
            @(negedge clk); n++;
            chk("other_grant", port ? bus.i_grant_out : bus.d_grant_out, 0);
            if (port ? bus.d_fill_out : bus.i_fill_out) begin
                got = 1;
                chk("latency", n, LAT + 1);
                chk("fill_grant", port ? bus.d_grant_out : bus.i_grant_out, 1);
                chk("fill_addr", bus.fill_addr_out, align(addr));
                chk("fill_write", bus.fill_write_out, wr);
                chk("fill_data", bus.fill_data_out, exp_d);
            end else begin
                chk("busy_grant", port ? bus.d_grant_out : bus.i_grant_out, 1);
            end
        end
        if (!got) chk("timeout", 0, 1);
        bus.i_req_in = 0; bus.d_req_in = 0; bus.d_write_in = 0;
        if (wr) mem_m[idx_of(addr)] = data;
        last_m = port;
        @(negedge clk);
        chk_idle_outs("post");
    endtask

    // Both ports request reads in the same cycle.
    task automatic simul(input logic [AW-1:0] ai, input logic [AW-1:0] ad);
        int cyc = 0, ti = -1, td = -1;
        bit d_first_exp;
`ifdef MEM_CTRL_RR_ARB_EN
        d_first_exp = ~last_m;
`else
        d_first_exp = 1'b1;
`endif
        @(negedge clk);
        bus.i_req_in = 1; bus.i_addr_in = ai;
        bus.d_req_in = 1; bus.d_write_in = 0; bus.d_addr_in = ad;
        while ((ti < 0 || td < 0) && cyc < 60) begin
            @(negedge clk); cyc++;
            chk("one_grant", bus.i_grant_out & bus.d_grant_out, 0);
            if (bus.i_fill_out) begin
                ti = cyc; bus.i_req_in = 0;
                chk("sim_i_data", bus.fill_data_out, mem_m[idx_of(ai)]);
            end
            if (bus.d_fill_out) begin
                td = cyc; bus.d_req_in = 0;
                chk("sim_d_data", bus.fill_data_out, mem_m[idx_of(ad)]);
            end
        end
        bus.i_req_in = 0; bus.d_req_in = 0;
        if (ti < 0 || td < 0) chk("sim_timeout", 0, 1);
        else begin
            chk("sim_d_first", td < ti, d_first_exp);
            chk("sim_gap", d_first_exp ? ti - td : td - ti, LAT + 2);
            last_m = ~d_first_exp;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [AW-1:0] bases [6] = '{32'h0, 32'h40, 32'h80, 32'h100, 32'h1F0, 32'hFFF0};
        logic [LW-1:0] line_a;
        reset = 0;
        bus.i_req_in = 0; bus.i_addr_in = '0;
        bus.d_req_in = 0; bus.d_write_in = 0; bus.d_addr_in = '0; bus.d_data_in = '0;
        repeat (3) @(negedge clk);
        chk_idle_outs("reset");
        reset = 1;
        @(negedge clk);
        chk_idle_outs("idle");

        xact(1, 1, 32'h40, 128'hDEADBEEF_00000001_22222222_33333333);
        xact(0, 0, 32'h4C, '0);
        xact(0, 0, 32'h10040, '0);
        line_a = {$urandom, $urandom, $urandom, $urandom};
        xact(1, 1, 32'h80, line_a);
        xact(1, 1, 32'h100, {$urandom, $urandom, $urandom, $urandom});

        // Reset during BUSY cycle 3 of a write: write must be dropped.
        @(negedge clk);
        bus.d_req_in = 1; bus.d_write_in = 1; bus.d_addr_in = 32'h80;
        bus.d_data_in = ~line_a;
        repeat (3) @(negedge clk);
        chk("rst_busy_grant", bus.d_grant_out, 1);
        reset = 0;
        #1;
        chk_idle_outs("rst_mid");
        bus.d_req_in = 0; bus.d_write_in = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        last_m = 1'b0;
        xact(0, 0, 32'h80, '0);

        // icache last, so both arbitration modes expect d, i, d, i.
        xact(0, 0, 32'h100, '0);
        simul(32'h40, 32'h80);
        simul(32'h100, 32'h10044);

        for (int k = 0; k < 20; k++) begin
            logic [AW-1:0] a;
            bit p, w;
            a = bases[$urandom_range(0, 5)] + ($urandom_range(0, 3) << 16) + $urandom_range(0, 15);
            p = 1'($urandom_range(0, 1));
            w = p & 1'($urandom_range(0, 1));
            if (!mem_m.exists(idx_of(a))) begin p = 1; w = 1; end
            xact(p, w, a, {$urandom, $urandom, $urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
